// File: rtl/code_entry_sequencer.sv
// Keypad-side initiator for comb_lock: buffers digits, replays them in comb_lock's timing, reports the outcome.
// Optional macro AUTO_SUBMIT_EN: start the attempt as soon as the last digit is buffered (submit unused).
module code_entry_sequencer #(
   parameter int NUM_DIGITS = 4,
   parameter int DIGIT_W    = 4,
   parameter int GAP_CYCLES = 1,
   parameter int RESP_WAIT  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               key_valid,
   input  logic [DIGIT_W-1:0] key_data,
   output logic               key_ready,
   input  logic               submit,
   input  logic               clear,
   input  logic               grant,
   input  logic               deny,
   input  logic               lock,
   output logic               enter_button,
   output logic [DIGIT_W-1:0] ip_pass,
   output logic               busy,
   output logic [2:0]         digit_count,
   output logic               result_valid,
   output logic [1:0]         result,
   output logic               short_err
);
   localparam int CNT_A   = (GAP_CYCLES > NUM_DIGITS) ? GAP_CYCLES : NUM_DIGITS;
   localparam int CNT_MAX = (RESP_WAIT > CNT_A) ? RESP_WAIT : CNT_A;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_ENTER, S_GAP, S_DIGIT, S_RESP, S_DENY_CHK, S_LOCKWAIT
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [2:0]         count_q, count_d;
   logic [DIGIT_W-1:0] buf_q [NUM_DIGITS];
   logic               enter_q, enter_d;
   logic [DIGIT_W-1:0] ip_q, ip_d;
   logic               busy_q, busy_d;
   logic               rv_q, rv_d;
   logic [1:0]         res_q, res_d;
   logic               serr_q, serr_d;

   logic key_fire, full, buf_we, start_attempt, short_submit;

   assign key_ready = (state_q == S_IDLE) && (count_q < 3'(NUM_DIGITS));
   assign key_fire  = key_valid && key_ready;
   assign full      = (count_q == 3'(NUM_DIGITS));
   assign buf_we    = key_fire && !clear;

`ifdef AUTO_SUBMIT_EN
   assign start_attempt = full;
   assign short_submit  = 1'b0;
`else
   assign start_attempt = submit && full;
   assign short_submit  = submit && !full;
`endif

   // Digit buffer, written at the current count so digits replay in entry order.
   for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_buf
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            buf_q[gi] <= '0;
         end else if (buf_we && (count_q[IDX_W-1:0] == IDX_W'(gi))) begin
            buf_q[gi] <= key_data;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      count_d = count_q;
      rv_d    = 1'b0;
      res_d   = res_q;
      serr_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start_attempt) begin
               state_d = S_ENTER;
               cnt_d   = '0;
            end else begin
               serr_d = short_submit;
               if (clear) begin
                  count_d = '0;
               end else if (key_fire) begin
                  count_d = count_q + 3'd1;
               end
            end
         end
         S_ENTER: begin
            state_d = S_GAP;
            cnt_d   = '0;
         end
         S_GAP: begin
            if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
               state_d = S_DIGIT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DIGIT: begin
            if (cnt_q == CNT_W'(NUM_DIGITS - 1)) begin
               state_d = S_RESP;
               cnt_d   = '0;
               count_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RESP: begin
            // A deny may be followed by lock one cycle later, so it is confirmed in DENY_CHK.
            if (grant) begin
               state_d = S_IDLE;
               rv_d    = 1'b1;
               res_d   = 2'b01;
            end else if (lock) begin
               state_d = S_LOCKWAIT;
               rv_d    = 1'b1;
               res_d   = 2'b11;
            end else if (deny) begin
               state_d = S_DENY_CHK;
            end else if (cnt_q == CNT_W'(RESP_WAIT - 1)) begin
               state_d = S_IDLE;
               rv_d    = 1'b1;
               res_d   = 2'b00;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DENY_CHK: begin
            rv_d = 1'b1;
            if (lock) begin
               state_d = S_LOCKWAIT;
               res_d   = 2'b11;
            end else begin
               state_d = S_IDLE;
               res_d   = 2'b10;
            end
         end
         S_LOCKWAIT: begin
            if (!lock) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      enter_d = (state_d == S_ENTER);
      busy_d  = (state_d != S_IDLE);
      ip_d    = (state_d == S_DIGIT) ? buf_q[cnt_d[IDX_W-1:0]] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         count_q <= '0;
         enter_q <= 1'b0;
         ip_q    <= '0;
         busy_q  <= 1'b0;
         rv_q    <= 1'b0;
         res_q   <= 2'b00;
         serr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         count_q <= count_d;
         enter_q <= enter_d;
         ip_q    <= ip_d;
         busy_q  <= busy_d;
         rv_q    <= rv_d;
         res_q   <= res_d;
         serr_q  <= serr_d;
      end
   end

   assign enter_button = enter_q;
   assign ip_pass      = ip_q;
   assign busy         = busy_q;
   assign digit_count  = count_q;
   assign result_valid = rv_q;
   assign result       = res_q;
   assign short_err    = serr_q;

endmodule

// File: tb/tb_code_entry_sequencer.sv
// Scoreboard bench for code_entry_sequencer: stimulus pushes expected enter/digit/result/short_err
// events with their cycle numbers, a negedge monitor pops and compares them as the DUT produces them.
module tb_code_entry_sequencer;
   localparam int NUM_DIGITS = 4;
   localparam int DIGIT_W    = 4;
   localparam int GAP_CYCLES = 1;
   localparam int RESP_WAIT  = 8;

   typedef enum int {R_GRANT, R_DENY, R_LOCK, R_NONE, R_RESET} resp_t;
   typedef struct {
      int         cyc;
      logic [1:0] res;
   } exp_res_t;

   logic               clk = 1'b0;
   logic               rst_n = 1'b1;
   logic               key_valid = 1'b0;
   logic [DIGIT_W-1:0] key_data = '0;
   logic               submit = 1'b0;
   logic               clear = 1'b0;
   logic               grant = 1'b0;
   logic               deny = 1'b0;
   logic               lock = 1'b0;
   logic               key_ready, enter_button, busy, result_valid, short_err;
   logic [DIGIT_W-1:0] ip_pass;
   logic [2:0]         digit_count;
   logic [1:0]         result;

   int                 cyc = 0;
   int                 n_checks = 0;
   int                 n_fail = 0;
   int                 exp_enter[$];
   logic [DIGIT_W-1:0] exp_dig[$];
   exp_res_t           exp_res[$];
   int                 exp_short[$];
   logic [DIGIT_W-1:0] mdl[$];
   int                 dig_start = -1000;
   logic [1:0]         last_res = 2'b00;
   exp_res_t           mon_e;

   code_entry_sequencer #(
      .NUM_DIGITS(NUM_DIGITS), .DIGIT_W(DIGIT_W), .GAP_CYCLES(GAP_CYCLES), .RESP_WAIT(RESP_WAIT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_data(key_data), .key_ready(key_ready),
      .submit(submit), .clear(clear), .grant(grant), .deny(deny), .lock(lock),
      .enter_button(enter_button), .ip_pass(ip_pass), .busy(busy), .digit_count(digit_count),
      .result_valid(result_valid), .result(result), .short_err(short_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   // Monitor: every event the DUT emits must match the head of its queue.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_enter.delete();
         exp_dig.delete();
         exp_res.delete();
         exp_short.delete();
         dig_start = -1000;
         last_res  = 2'b00;
      end else begin
         if (enter_button) begin
            check("enter_pending", exp_enter.size() != 0, 1);
            if (exp_enter.size() != 0) check("enter_cyc", cyc, exp_enter.pop_front());
            dig_start = cyc + 1 + GAP_CYCLES;
         end
         if (cyc >= dig_start && cyc < dig_start + NUM_DIGITS) begin
            check("dig_pending", exp_dig.size() != 0, 1);
            if (exp_dig.size() != 0) check("ip_pass", ip_pass, exp_dig.pop_front());
         end else begin
            check("ip_idle", ip_pass, 0);
         end
         if (result_valid) begin
            check("res_pending", exp_res.size() != 0, 1);
            if (exp_res.size() != 0) begin
               mon_e = exp_res.pop_front();
               check("res_cyc", cyc, mon_e.cyc);
               check("result", result, mon_e.res);
            end
            last_res = result;
            $display("[cyc %0d] result_valid result=%b", cyc, result);
         end else begin
            check("res_hold", result, last_res);
         end
         if (short_err) begin
            check("short_pending", exp_short.size() != 0, 1);
            if (exp_short.size() != 0) check("short_cyc", cyc, exp_short.pop_front());
            $display("[cyc %0d] short_err", cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_key(input logic [DIGIT_W-1:0] d);
      logic exp_rdy;
      exp_rdy   = (mdl.size() < NUM_DIGITS);
      key_valid = 1'b1;
      key_data  = d;
      check("key_ready", key_ready, exp_rdy);
      tick();
      key_valid = 1'b0;
      if (exp_rdy) mdl.push_back(d);
      check("digit_count", digit_count, mdl.size());
      $display("[cyc %0d] key %0d offered accepted=%0d count=%0d", cyc, d, exp_rdy, digit_count);
   endtask

   task automatic send4(input int a, input int b, input int c, input int d);
      send_key(DIGIT_W'(a));
      send_key(DIGIT_W'(b));
      send_key(DIGIT_W'(c));
      send_key(DIGIT_W'(d));
   endtask

   task automatic clear_keys();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      mdl.delete();
      check("clear_count", digit_count, 0);
      $display("[cyc %0d] clear count=%0d", cyc, digit_count);
   endtask

   task automatic short_submit();
      exp_short.push_back(cyc + 1);
      submit = 1'b1;
      tick();
      submit = 1'b0;
      check("short_count", digit_count, mdl.size());
      tick();
   endtask

   task automatic attempt(input resp_t kind);
      int       t;
      exp_res_t e;
      t = cyc;
      submit = 1'b1;
      exp_enter.push_back(t + 1);
      foreach (mdl[i]) exp_dig.push_back(mdl[i]);
      mdl.delete();
      case (kind)
         R_GRANT: begin e.cyc = t + 8; e.res = 2'b01; end
         R_DENY:  begin e.cyc = t + 9; e.res = 2'b10; end
         R_LOCK:  begin e.cyc = t + 9; e.res = 2'b11; end
         R_NONE:  begin e.cyc = t + 7 + RESP_WAIT; e.res = 2'b00; end
         default: begin e.cyc = 0; e.res = 2'b00; end
      endcase
      if (kind != R_RESET) exp_res.push_back(e);
      $display("[cyc %0d] submit kind=%0d", cyc, kind);
      tick();
      submit = 1'b0;
      while (cyc < t + 7) begin
         if (cyc == t + 4) begin
            if (kind == R_RESET) begin
               #1 rst_n = 1'b0;
               #1;
               check("rst_enter", enter_button, 0);
               check("rst_ip", ip_pass, 0);
               check("rst_busy", busy, 0);
               check("rst_count", digit_count, 0);
               check("rst_rv", result_valid, 0);
               check("rst_result", result, 0);
               check("rst_short", short_err, 0);
               check("rst_key_ready", key_ready, 1);
               tick();
               rst_n = 1'b1;
               check("rel_key_ready", key_ready, 1);
               check("rel_count", digit_count, 0);
               repeat (12) begin
                  tick();
                  check("rel_busy", busy, 0);
               end
               return;
            end
            // submit/clear while busy must not disturb the attempt in flight.
            submit = 1'b1;
            clear  = 1'b1;
            tick();
            submit = 1'b0;
            clear  = 1'b0;
         end else begin
            tick();
         end
      end
      grant = (kind == R_GRANT);
      deny  = (kind == R_DENY) || (kind == R_LOCK);
      tick();
      grant = 1'b0;
      deny  = 1'b0;
      if (kind == R_LOCK) begin
         lock = 1'b1;
         while (cyc < t + 13) begin
            tick();
            check("lock_busy", busy, 1);
            check("lock_key_ready", key_ready, 0);
         end
         lock = 1'b0;
         tick();
         check("unlock_busy", busy, 0);
         check("unlock_key_ready", key_ready, 1);
      end else begin
         while (cyc < e.cyc) tick();
         check("idle_busy", busy, 0);
         check("idle_key_ready", key_ready, 1);
      end
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst_n = 1'b0;
      #2;
      check("reset_enter", enter_button, 0);
      check("reset_ip", ip_pass, 0);
      check("reset_busy", busy, 0);
      check("reset_count", digit_count, 0);
      check("reset_rv", result_valid, 0);
      check("reset_result", result, 0);
      check("reset_short", short_err, 0);
      check("reset_key_ready", key_ready, 1);
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();

      send4(1, 5, 3, 7);
      attempt(R_GRANT);
      send4(2, 0, 0, 0);
      attempt(R_DENY);
      send4(2, 0, 0, 1);
      attempt(R_DENY);
      send4(2, 0, 0, 2);
      attempt(R_LOCK);

      send4(4, 4, 4, 4);
      send_key(4'd9);
      clear_keys();
      send_key(4'd6);
      send_key(4'd6);
      send_key(4'd6);
      short_submit();
      clear_keys();

      send4(9, 8, 7, 6);
      attempt(R_NONE);
      send4(8, 6, 7, 5);
      attempt(R_GRANT);
      send4(3, 1, 4, 1);
      attempt(R_RESET);
      send4(2, 4, 6, 8);
      attempt(R_GRANT);

      repeat (3) tick();
      check("enter_q_empty", exp_enter.size(), 0);
      check("dig_q_empty", exp_dig.size(), 0);
      check("res_q_empty", exp_res.size(), 0);
      check("short_q_empty", exp_short.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
